// File: rtl/ubtb_update_sched_pkg.sv
// Shared types and defaults for the micro-BTB update scheduler.
// Tag width follows the uBTB tag-size define so both sides stay in step.
`ifndef UBTB_TAG_SIZE
`define UBTB_TAG_SIZE 8
`endif

package ubtb_update_sched_pkg;

   localparam int UBTB_TAG_W      = `UBTB_TAG_SIZE;
   localparam int UBTB_DATA_W     = 64;
   localparam int UBTB_UPD_DEPTH  = 4;
   localparam int UBTB_STARVE_MAX = 3;

   typedef struct packed {
      logic [UBTB_TAG_W-1:0]  tag;
      logic [UBTB_DATA_W-1:0] data;
   } UBtbUpdReq;

endpackage

// File: rtl/ubtb_update_sched_if.sv
// Request/update bus of the uBTB update scheduler.
// master = FSQ/BPU + uBTB side, slave = scheduler.
interface ubtb_update_sched_if
   import ubtb_update_sched_pkg::*;
#(
   parameter int TAG_W  = UBTB_TAG_W,
   parameter int DATA_W = UBTB_DATA_W,
   parameter int DEPTH  = UBTB_UPD_DEPTH
) ();

   logic                     flush;
   logic                     cmt_valid;
   logic                     cmt_ready;
   logic [TAG_W-1:0]         cmt_tag;
   logic [DATA_W-1:0]        cmt_data;
   logic                     pred_valid;
   logic                     pred_ready;
   logic [TAG_W-1:0]         pred_tag;
   logic [DATA_W-1:0]        pred_data;
   logic                     upd_valid;
   logic                     upd_ready;
   logic [TAG_W-1:0]         upd_tag;
   logic [DATA_W-1:0]        upd_data;
   logic [$clog2(DEPTH):0]   occupancy;

   modport master (
      output flush, cmt_valid, cmt_tag, cmt_data,
      output pred_valid, pred_tag, pred_data, upd_ready,
      input  cmt_ready, pred_ready, upd_valid, upd_tag, upd_data, occupancy
   );

   modport slave (
      input  flush, cmt_valid, cmt_tag, cmt_data,
      input  pred_valid, pred_tag, pred_data, upd_ready,
      output cmt_ready, pred_ready, upd_valid, upd_tag, upd_data, occupancy
   );

endinterface

// File: rtl/ubtb_upd_arbiter.sv
// Two-port priority arbiter: commit wins unless the correction port has lost
// STARVE_MAX cycles in a row, in which case the correction port is forced through.
module ubtb_upd_arbiter
   import ubtb_update_sched_pkg::*;
#(
   parameter int TAG_W      = UBTB_TAG_W,
   parameter int DATA_W     = UBTB_DATA_W,
   parameter int STARVE_MAX = UBTB_STARVE_MAX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_cmt_valid,
   input  logic [TAG_W-1:0]  i_cmt_tag,
   input  logic [DATA_W-1:0] i_cmt_data,
   input  logic              i_pred_valid,
   input  logic [TAG_W-1:0]  i_pred_tag,
   input  logic [DATA_W-1:0] i_pred_data,
   input  logic              i_pred_acc,
   output logic              o_gnt_cmt,
   output logic              o_gnt_pred,
   output logic [TAG_W-1:0]  o_sel_tag,
   output logic [DATA_W-1:0] o_sel_data
);

   localparam int            SW   = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

   logic [SW-1:0] r_starve;
   logic          w_force;

   assign w_force    = (r_starve == SMAX) & i_pred_valid;
   assign o_gnt_cmt  = i_cmt_valid & ~w_force;
   assign o_gnt_pred = i_pred_valid & ~o_gnt_cmt;
   assign o_sel_tag  = o_gnt_pred ? i_pred_tag  : i_cmt_tag;
   assign o_sel_data = o_gnt_pred ? i_pred_data : i_cmt_data;

   // A granted-but-blocked pred (queue full) neither counts as a loss nor clears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve <= '0;
      end else if (i_flush || !i_pred_valid || i_pred_acc) begin
         r_starve <= '0;
      end else if (o_gnt_cmt && r_starve != SMAX) begin
         r_starve <= r_starve + 1'b1;
      end
   end

endmodule

// File: rtl/ubtb_update_sched.sv
// Coalescing update queue in front of the single uBTB update port.
// Same-tag writes merge in place; FIFO order follows first allocation.
module ubtb_update_sched
   import ubtb_update_sched_pkg::*;
#(
   parameter int DEPTH      = UBTB_UPD_DEPTH,
   parameter int TAG_W      = UBTB_TAG_W,
   parameter int DATA_W     = UBTB_DATA_W,
   parameter int STARVE_MAX = UBTB_STARVE_MAX
) (
   input  logic                clk,
   input  logic                rst,
   ubtb_update_sched_if.slave  io_bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [TAG_W-1:0]  r_tag  [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [DEPTH-1:0]  r_vld;
   logic [PW-1:0]     r_head;
   logic [PW-1:0]     r_tail;
   logic [CW-1:0]     r_cnt;

   logic              w_gnt_cmt;
   logic              w_gnt_pred;
   logic [TAG_W-1:0]  w_sel_tag;
   logic [DATA_W-1:0] w_sel_data;
   logic              w_deq;
   logic              w_full;
   logic [DEPTH-1:0]  w_hit;
   logic              w_any_hit;
   logic [PW-1:0]     w_hit_idx;
   logic              w_can;
   logic              w_acc;
   logic              w_alloc;
   logic              w_coal;
   logic              w_cmt_rdy;
   logic              w_pred_rdy;

   ubtb_upd_arbiter #(
      .TAG_W      (TAG_W),
      .DATA_W     (DATA_W),
      .STARVE_MAX (STARVE_MAX)
   ) u_arb (
      .clk          (clk),
      .rst          (rst),
      .i_flush      (io_bus.flush),
      .i_cmt_valid  (io_bus.cmt_valid),
      .i_cmt_tag    (io_bus.cmt_tag),
      .i_cmt_data   (io_bus.cmt_data),
      .i_pred_valid (io_bus.pred_valid),
      .i_pred_tag   (io_bus.pred_tag),
      .i_pred_data  (io_bus.pred_data),
      .i_pred_acc   (w_pred_rdy),
      .o_gnt_cmt    (w_gnt_cmt),
      .o_gnt_pred   (w_gnt_pred),
      .o_sel_tag    (w_sel_tag),
      .o_sel_data   (w_sel_data)
   );

   assign w_deq  = r_vld[r_head] & io_bus.upd_ready;
   assign w_full = (r_cnt == CW'(DEPTH));

   // The head leaving this cycle must not absorb a merge, or the write is lost.
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_hit[i] = r_vld[i] && (r_tag[i] == w_sel_tag) &&
                    !(w_deq && (PW'(i) == r_head));
      end
   end

   // Tags are unique in the queue, so OR-ing the indices is a valid encoder.
   always_comb begin
      w_hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_hit[i]) w_hit_idx = w_hit_idx | PW'(i);
      end
   end

   assign w_any_hit  = |w_hit;
   assign w_can      = ~rst & ~io_bus.flush & (w_any_hit | ~w_full | w_deq);
   assign w_cmt_rdy  = w_gnt_cmt & w_can;
   assign w_pred_rdy = w_gnt_pred & w_can;
   assign w_acc      = w_cmt_rdy | w_pred_rdy;
   assign w_alloc    = w_acc & ~w_any_hit;
   assign w_coal     = w_acc & w_any_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_tag[i]  <= '0;
            r_data[i] <= '0;
         end
         r_vld  <= '0;
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else if (io_bus.flush) begin
         r_vld  <= '0;
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_deq) begin
            r_vld[r_head] <= 1'b0;
            r_head        <= r_head + 1'b1;
         end
         if (w_coal) begin
            r_data[w_hit_idx] <= w_sel_data;
         end
         // Full+dequeue reuses the slot being freed; the later set wins.
         if (w_alloc) begin
            r_vld[r_tail]  <= 1'b1;
            r_tag[r_tail]  <= w_sel_tag;
            r_data[r_tail] <= w_sel_data;
            r_tail         <= r_tail + 1'b1;
         end
         r_cnt <= r_cnt + CW'(w_alloc) - CW'(w_deq);
      end
   end

   assign io_bus.cmt_ready  = w_cmt_rdy;
   assign io_bus.pred_ready = w_pred_rdy;
   assign io_bus.upd_valid  = r_vld[r_head];
   assign io_bus.upd_tag    = r_tag[r_head];
   assign io_bus.upd_data   = r_data[r_head];
   assign io_bus.occupancy  = r_cnt;

endmodule

// File: tb/tb_ubtb_update_sched.sv
// Randomized + directed bench for ubtb_update_sched against a queue-based model.
module tb_ubtb_update_sched;
   import ubtb_update_sched_pkg::*;

   localparam int DEPTH = 4;
   localparam int SMAX  = 3;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;
   bit   last_cr;
   bit   last_pr;

   UBtbUpdReq mq[$];
   int        m_starve;

   ubtb_update_sched_if #(.TAG_W(8), .DATA_W(64), .DEPTH(DEPTH)) bus ();

   ubtb_update_sched #(
      .DEPTH(DEPTH), .TAG_W(8), .DATA_W(64), .STARVE_MAX(SMAX)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      bus.flush      = 1'b0;
      bus.cmt_valid  = 1'b0;
      bus.cmt_tag    = '0;
      bus.cmt_data   = '0;
      bus.pred_valid = 1'b0;
      bus.pred_tag   = '0;
      bus.pred_data  = '0;
      bus.upd_ready  = 1'b0;
   endtask

   // One clock: drive at negedge, check outputs against the model, advance the model.
   task automatic cyc(input bit fl, input bit cv, input logic [7:0] ct, input logic [63:0] cd,
                      input bit pv, input logic [7:0] pt, input logic [63:0] pd, input bit ur);
      bit              deq, win_c, win_p, hit, can, exp_cr, exp_pr;
      int              hj;
      logic [7:0]      wtag;
      logic [63:0]     wdata;
      UBtbUpdReq       e;
      @(negedge clk);
      bus.flush = fl; bus.cmt_valid = cv; bus.cmt_tag = ct; bus.cmt_data = cd;
      bus.pred_valid = pv; bus.pred_tag = pt; bus.pred_data = pd; bus.upd_ready = ur;
      #1;
      chk("upd_valid", bus.upd_valid, 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("upd_tag", bus.upd_tag, mq[0].tag);
         chk("upd_data", bus.upd_data, mq[0].data);
      end
      chk("occupancy", bus.occupancy, mq.size());
      deq   = (mq.size() != 0) && ur;
      win_c = cv && !(m_starve == SMAX && pv);
      win_p = !win_c && pv;
      wtag  = win_p ? pt : ct;
      wdata = win_p ? pd : cd;
      hit   = 0;
      hj    = 0;
      for (int j = (deq ? 1 : 0); j < mq.size(); j++) begin
         if (mq[j].tag == wtag) begin hit = 1; hj = j; end
      end
      can    = !fl && (hit || mq.size() < DEPTH || deq);
      exp_cr = win_c && can;
      exp_pr = win_p && can;
      chk("cmt_ready", bus.cmt_ready, 64'(exp_cr));
      chk("pred_ready", bus.pred_ready, 64'(exp_pr));
      last_cr = bus.cmt_ready;
      last_pr = bus.pred_ready;
      @(posedge clk);
      if (fl) begin
         mq.delete();
         m_starve = 0;
      end else begin
         if (deq) void'(mq.pop_front());
         if (exp_cr || exp_pr) begin
            if (hit) begin
               mq[hj - (deq ? 1 : 0)].data = wdata;
            end else begin
               e.tag  = wtag;
               e.data = wdata;
               mq.push_back(e);
            end
         end
         if (!pv || exp_pr) m_starve = 0;
         else if (win_c && m_starve < SMAX) m_starve++;
      end
   endtask

   task automatic idle(input bit ur);
      cyc(0, 0, 8'h00, 64'h0, 0, 8'h00, 64'h0, ur);
   endtask

   initial begin
      n_chk = 0; n_err = 0; m_starve = 0;
      rst = 1'b1;
      drive_idle();
      bus.cmt_valid  = 1'b1;
      bus.pred_valid = 1'b1;
      #2;
      chk("rst_upd_valid", bus.upd_valid, 0);
      chk("rst_occ", bus.occupancy, 0);
      chk("rst_cmt_ready", bus.cmt_ready, 0);
      chk("rst_pred_ready", bus.pred_ready, 0);
      chk("rst_upd_tag", bus.upd_tag, 0);
      chk("rst_upd_data", bus.upd_data, 0);
      drive_idle();
      @(negedge clk);
      rst = 1'b0;

      // single commit, 1-cycle latency
      cyc(0, 1, 8'h12, 64'h1111, 0, 8'h00, 64'h0, 1);
      #1 chk("t1_valid", bus.upd_valid, 1);
      chk("t1_tag", bus.upd_tag, 8'h12);
      chk("t1_occ", bus.occupancy, 1);
      idle(1);
      #1 chk("t1_drained", bus.occupancy, 0);

      // coalesce in place
      cyc(0, 1, 8'h05, 64'hAAAA, 0, 8'h00, 64'h0, 0);
      cyc(0, 1, 8'h07, 64'h7777, 0, 8'h00, 64'h0, 0);
      cyc(0, 1, 8'h05, 64'hBBBB, 0, 8'h00, 64'h0, 0);
      #1 chk("t2_occ", bus.occupancy, 2);
      chk("t2_head_tag", bus.upd_tag, 8'h05);
      chk("t2_head_data", bus.upd_data, 64'hBBBB);
      idle(1);
      #1 chk("t2_second", bus.upd_tag, 8'h07);
      idle(1);

      // full, then full + dequeue
      for (int k = 0; k < 4; k++) cyc(0, 1, 8'(8'h20 + k), 64'(k), 0, 8'h00, 64'h0, 0);
      cyc(0, 1, 8'h30, 64'h3030, 0, 8'h00, 64'h0, 0);
      chk("t3_full_block", last_cr, 0);
      cyc(0, 1, 8'h30, 64'h3030, 0, 8'h00, 64'h0, 1);
      chk("t3_full_deq_ok", last_cr, 1);
      #1 chk("t3_occ", bus.occupancy, 4);
      chk("t3_head", bus.upd_tag, 8'h21);
      for (int k = 0; k < 4; k++) idle(1);

      // anti-starvation
      for (int k = 0; k < 5; k++) begin
         cyc(0, 1, 8'(8'h40 + k), 64'(k), 1, 8'h50, 64'h5050, 1);
         chk("t4_pred_ready", last_pr, (k == 3) ? 1 : 0);
      end
      idle(1); idle(1);

      // same-tag collision
      cyc(0, 1, 8'h3A, 64'hC0C0, 1, 8'h3A, 64'hD0D0, 0);
      chk("t5_cmt_win", last_cr, 1);
      chk("t5_pred_lose", last_pr, 0);
      cyc(0, 0, 8'h00, 64'h0, 1, 8'h3A, 64'hD0D0, 0);
      chk("t5_pred_acc", last_pr, 1);
      #1 chk("t5_occ", bus.occupancy, 1);
      chk("t5_data", bus.upd_data, 64'hD0D0);
      idle(1);

      // flush, then async reset mid-transfer
      for (int k = 0; k < 3; k++) cyc(0, 1, 8'(8'h60 + k), 64'(k), 0, 8'h00, 64'h0, 0);
      cyc(1, 1, 8'h70, 64'h7070, 0, 8'h00, 64'h0, 0);
      chk("t6_flush_rdy", last_cr, 0);
      #1 chk("t6_flush_occ", bus.occupancy, 0);
      chk("t6_flush_valid", bus.upd_valid, 0);
      cyc(0, 1, 8'h71, 64'h7171, 0, 8'h00, 64'h0, 0);
      cyc(0, 1, 8'h72, 64'h7272, 0, 8'h00, 64'h0, 1);
      #2 drive_idle();
      #1 rst = 1'b1;
      #1 chk("t6_rst_valid", bus.upd_valid, 0);
      chk("t6_rst_occ", bus.occupancy, 0);
      chk("t6_rst_tag", bus.upd_tag, 0);
      chk("t6_rst_data", bus.upd_data, 0);
      mq.delete();
      m_starve = 0;
      @(negedge clk);
      rst = 1'b0;

      // random: slow drain, then fast drain
      for (int k = 0; k < 3000; k++) begin
         cyc($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
             8'($urandom_range(0, 5)), {$urandom, $urandom},
             $urandom_range(0, 1) == 1, 8'($urandom_range(0, 5)), {$urandom, $urandom},
             (k < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ubtb_update_sched.md
Name: ubtb_update_sched

Overview:
- Buffers and sequences micro-BTB update requests onto the single uBTB update port.
- Two requesters feed it:
  - commit path (FSQ commit, high priority);
  - predictor-correction path (s3 override, low priority, with anti-starvation).
- Same-tag requests already queued are coalesced in place, so the uBTB sees at most one pending write per tag.
- Sits between the FSQ/BPU and the uBTB update interface.

Parameters:
- DEPTH, 4, queue entries (power of 2, >=2).
- TAG_W, 8, uBTB tag width (matches uBTB tag size).
- DATA_W, 64, opaque update payload width (BTB entry + ctr meta + realTaken).
- STARVE_MAX, 3, consecutive lost cycles before the pred port is forced to win.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  drop all queued updates.
- cmt_valid  in  1  commit update request.
- cmt_ready  out  1  commit request accepted this cycle.
- cmt_tag  in  TAG_W  commit update tag.
- cmt_data  in  DATA_W  commit payload.
- pred_valid  in  1  correction update request.
- pred_ready  out  1  correction request accepted.
- pred_tag  in  TAG_W  correction tag.
- pred_data  in  DATA_W  correction payload.
- upd_valid  out  1  head entry valid toward uBTB.
- upd_ready  in  1  uBTB consumes head.
- upd_tag  out  TAG_W  head tag.
- upd_data  out  DATA_W  head payload.
- occupancy  out  $clog2(DEPTH)+1  valid entries.

Behaviour:
- Reset state: queue empty, head/tail ptr 0, starve counter 0. Outputs upd_valid=0, occupancy=0, cmt_ready=0, pred_ready=0; upd_tag/upd_data=0.
- Storage: circular FIFO with head/tail pointers and per-entry valid bits. upd_* driven directly from the head entry, registered, with no input-to-output comb path.
- Dequeue: upd_valid & upd_ready, then the head is popped (0-cycle handshake).
- One enqueue or coalesce per cycle, decided by the arbiter:
  - Winner is cmt if cmt_valid, unless starve==STARVE_MAX and pred_valid, in which case pred wins.
  - Otherwise pred wins if pred_valid.
  - Loser's ready is 0.
- Starve counter:
  - Increments (saturating) when pred_valid is high and pred loses.
  - Clears when pred is accepted or pred_valid is low.
- Coalesce: the winner's tag is compared against all valid entries.
  - Excluded from the compare: the head entry when it is dequeued in the same cycle.
  - On a match, payload is overwritten in place (newest wins) and occupancy is unchanged.
  - Matching on a tag is unique by construction.
- Allocate: no match and occupancy<DEPTH, then write at tail, tail++ (wraps mod DEPTH).
- Winner ready:
  - 1 if match, or occupancy<DEPTH, or (occupancy==DEPTH and dequeue this cycle).
  - The full+dequeue case gives enqueue and dequeue in the same cycle.
  - ready is never asserted when valid is low.
- Simultaneous cmt and pred with the same tag: only the winner is accepted. The loser retries next cycle and coalesces into the winner's entry.
- Enqueue and dequeue in the same cycle: occupancy unchanged, both pointers advance.
- Ordering: FIFO order by first allocation; a coalesced update keeps its original position.
- flush: next cycle queue is empty, pointers and starve reset.
  - Same-cycle input handshakes are ignored (ready forced 0).
  - A same-cycle dequeue still counts as consumed.
- rst mid-operation: immediate return to reset state; any in-flight payload is lost.
- Latency: accepted request to upd_valid is 1 cycle when the queue is empty.

Decomposition:
- Shared package gets:
  - a UBtbUpdReq struct {tag, data};
  - DEPTH, TAG_W and STARVE_MAX defaults, tied to the uBTB tag-size defines.
- One natural sub-module: ubtb_upd_arbiter. It is the two-port priority arbiter with the saturating starve counter and outputs the grant plus the selected tag/data.

Test Plan:
1. Single commit to empty queue: cmt tag 0x12 at cycle 0, upd_ready=1 → cycle 1 upd_valid=1, upd_tag=0x12, occupancy 1→0 at cycle 2.
2. Coalesce: upd_ready=0; cmt tag 0x05 data A, then cmt tag 0x07, then cmt tag 0x05 data B → occupancy=2, head tag 0x05 with data B, then 0x07.
3. Full + dequeue: fill 4 distinct tags, upd_ready=0; cmt_valid new tag → cmt_ready=0. Then upd_ready=1 same cycle → cmt_ready=1, occupancy stays 4.
4. Starvation: cmt_valid and pred_valid held high with distinct tags, queue draining every cycle → pred accepted on the 4th cycle (after 3 losses), starve clears.
5. Same-tag collision: cmt and pred both tag 0x3A in the same cycle → cmt accepted, pred_ready=0. Next cycle pred coalesces, occupancy=1, data=pred_data.
6. Flush/reset: 3 entries queued, flush=1 → next cycle occupancy=0, upd_valid=0. Async rst pulse mid-transfer → outputs 0 immediately.
